cnn_layer_sched: RTL and testbench
==================================

CNN_LAYER_SCHED -- requirements
Module: cnn_layer_sched

Interface
REQ-001 Parameters SHALL be: W_SIZE, default 12, image dimension width; W_FRAME_SIZE, default 2*W_SIZE+1, pixel-count width; W_DELAY, default 12, sync-delay width; FIFO_DEPTH, default 4, command queue entries (power of two).
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  queue not full.
- i_cmd_width  in  W_SIZE  frame width in pixels.
- i_cmd_height  in  W_SIZE  frame height in pixels.
- i_cmd_is_conv3x3  in  1  conv3x3 mode select.
- i_cmd_start_up_delay  in  W_DELAY  vsync delay.
- i_cmd_hsync_delay  in  W_DELAY  hsync delay.
- i_abort  in  1  flush queue.
- i_ctrl_vsync_run  in  1  frame FSM status.
- i_ctrl_hsync_run  in  1  frame FSM status.
- i_ctrl_data_run  in  1  frame FSM status.
- q_width, q_height  out  W_SIZE  frame FSM config.
- q_is_conv3x3  out  1  frame FSM config.
- q_start_up_delay, q_hsync_delay  out  W_DELAY  frame FSM config.
- q_frame_size  out  W_FRAME_SIZE  width*height.
- q_start  out  1  one-cycle frame start pulse.
- o_busy  out  1  scheduler not in IDLE.
- o_done  out  1  one-cycle frame-complete pulse.
- o_err  out  1  one-cycle rejected-command pulse.
- o_layer_cnt  out  16  completed frames, wraps.
- o_q_level  out  clog2(FIFO_DEPTH)+1  queue occupancy.

Function
REQ-003 A command SHALL be pushed on a cycle with i_cmd_valid && o_cmd_ready; o_cmd_ready SHALL be low exactly when the queue is full.
REQ-004 States SHALL be IDLE, LOAD, MUL, START, WAIT_RUN, WAIT_DONE.
REQ-005 IDLE->LOAD when the queue is non-empty and i_abort is low; LOAD pops the head and registers it into the q_* outputs.
REQ-006 In LOAD, a command with width==0 or height==0 SHALL be discarded, o_err pulsed the next cycle, and the state SHALL return to IDLE with q_* unchanged.
REQ-007 MUL SHALL register q_frame_size = q_width*q_height (full W_FRAME_SIZE result, no truncation at defaults), then go to START.
REQ-008 START SHALL drive q_start=1 for exactly one cycle, then go to WAIT_RUN.
REQ-009 WAIT_RUN->WAIT_DONE when any of the three *_run inputs is high.
REQ-010 WAIT_DONE->IDLE when all three *_run inputs are low; on that transition o_done SHALL pulse for one cycle and o_layer_cnt SHALL increment.
REQ-011 Minimum spacing from push into an empty idle queue to q_start SHALL be 4 cycles (IDLE, LOAD, MUL, START).
REQ-012 The q_* config outputs SHALL change only in LOAD/MUL and SHALL stay stable from START until o_done.
REQ-013 i_abort SHALL empty the queue on the cycle it is sampled. An in-flight frame (WAIT_RUN/WAIT_DONE) SHALL complete normally, including o_done. No new command SHALL launch while i_abort is high.
REQ-014 A push and a pop in the same cycle SHALL leave o_q_level unchanged. Push and abort in the same cycle: abort SHALL win and the pushed command SHALL be dropped.

Reset
REQ-015 With rstn low: state=IDLE, queue empty, all q_* = 0, q_start/o_done/o_err/o_busy = 0, o_layer_cnt = 0, o_cmd_ready = 1.
REQ-016 Reset mid-frame SHALL return to IDLE immediately. No o_done SHALL be issued for the interrupted frame.

Configuration
REQ-017 Macro CNN_SCHED_PERF_EN SHALL add output o_last_cycles (32 bits).
- Defined: o_last_cycles counts cycles from START to o_done inclusive, is loaded at o_done, and resets to 0.
- Undefined: the port and counter SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-018 State encodings and the default W_SIZE/W_DELAY/W_FRAME_SIZE constants SHALL live in a shared package used with the frame FSM.
REQ-019 The command queue SHALL be a sub-module, cnn_cmd_fifo, with synchronous push/pop/flush and level output.

Verification
REQ-020 Scenario: one command 8x4, conv3x3=0, delays 2/3, with a frame FSM model -> q_frame_size=32, q_start 4 cycles after push, one o_done, o_layer_cnt=1.
REQ-021 Scenario: push 5 commands back-to-back while busy (depth 4) -> o_cmd_ready low after 4 queued; all accepted commands complete in order; o_layer_cnt=4 or 5 as accepted.
REQ-022 Scenario: command with width=0 -> o_err pulse, no q_start, queue level decrements by 1.
REQ-023 Scenario: 3 queued, i_abort during frame 1 WAIT_DONE -> frame 1 o_done issued, o_q_level=0, no further q_start.
REQ-024 Scenario: rstn asserted during WAIT_DONE -> all outputs at reset values, no o_done.
REQ-025 Scenario: CNN_SCHED_PERF_EN defined, 4x4 conv3x3 frame -> o_last_cycles equals measured START-to-done count.

Source files
------------

// File: rtl/cnn_layer_sched_pkg.sv
// Shared constants for the CNN layer scheduler: default widths and the
// scheduler state encodings that the frame FSM side also decodes.
package cnn_layer_sched_pkg;

  localparam int W_SIZE_DEF       = 12;
  localparam int W_DELAY_DEF      = 12;
  localparam int W_FRAME_SIZE_DEF = 2*W_SIZE_DEF+1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LOAD      = 3'd1;
  localparam logic [2:0] S_MUL       = 3'd2;
  localparam logic [2:0] S_START     = 3'd3;
  localparam logic [2:0] S_WAIT_RUN  = 3'd4;
  localparam logic [2:0] S_WAIT_DONE = 3'd5;

  function automatic logic any_run(input logic v, input logic h, input logic d);
    return v | h | d;
  endfunction

endpackage

// File: rtl/cnn_layer_sched_cmd_fifo.sv
// Command queue: synchronous push/pop with a flush that overrides both.
module cnn_cmd_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic          wr, rd;

  assign full  = (lvl_q == (AW+1)'(DEPTH));
  assign empty = (lvl_q == '0);
  assign level = lvl_q;
  assign dout  = mem_q[rd_q];
  assign wr    = push && !full;
  assign rd    = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (wr) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + AW'(1);
      end
      if (rd) rd_d = rd_q + AW'(1);
      lvl_d = lvl_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
    end
  end

endmodule

// File: rtl/cnn_layer_sched.sv
// Layer scheduler: queues frame commands and hands them one at a time to the
// frame FSM. Optional CNN_SCHED_PERF_EN adds the o_last_cycles frame timer.
module cnn_layer_sched
  import cnn_layer_sched_pkg::*;
#(
  parameter int W_SIZE       = W_SIZE_DEF,
  parameter int W_FRAME_SIZE = 2*W_SIZE+1,
  parameter int W_DELAY      = W_DELAY_DEF,
  parameter int FIFO_DEPTH   = 4,
  localparam int LW          = $clog2(FIFO_DEPTH)+1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_cmd_valid,
  output logic                    o_cmd_ready,
  input  logic [W_SIZE-1:0]       i_cmd_width,
  input  logic [W_SIZE-1:0]       i_cmd_height,
  input  logic                    i_cmd_is_conv3x3,
  input  logic [W_DELAY-1:0]      i_cmd_start_up_delay,
  input  logic [W_DELAY-1:0]      i_cmd_hsync_delay,
  input  logic                    i_abort,
  input  logic                    i_ctrl_vsync_run,
  input  logic                    i_ctrl_hsync_run,
  input  logic                    i_ctrl_data_run,
  output logic [W_SIZE-1:0]       q_width,
  output logic [W_SIZE-1:0]       q_height,
  output logic                    q_is_conv3x3,
  output logic [W_DELAY-1:0]      q_start_up_delay,
  output logic [W_DELAY-1:0]      q_hsync_delay,
  output logic [W_FRAME_SIZE-1:0] q_frame_size,
  output logic                    q_start,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err,
  output logic [15:0]             o_layer_cnt,
  output logic [LW-1:0]           o_q_level
`ifdef CNN_SCHED_PERF_EN
  , output logic [31:0]           o_last_cycles
`endif
);

  localparam int CW = 2*W_SIZE + 1 + 2*W_DELAY;

  logic [CW-1:0]      push_data, head;
  logic               fifo_full, fifo_empty, pop, run;
  logic [W_SIZE-1:0]  hd_w, hd_h;
  logic               hd_c;
  logic [W_DELAY-1:0] hd_s, hd_d;

  logic [2:0]              state_q, state_d;
  logic [W_SIZE-1:0]       width_q, width_d, height_q, height_d;
  logic                    conv_q, conv_d;
  logic [W_DELAY-1:0]      sud_q, sud_d, hsd_q, hsd_d;
  logic [W_FRAME_SIZE-1:0] fsize_q, fsize_d;
  logic                    done_q, done_d, err_q, err_d;
  logic [15:0]             cnt_q, cnt_d;

  assign push_data = {i_cmd_width, i_cmd_height, i_cmd_is_conv3x3,
                      i_cmd_start_up_delay, i_cmd_hsync_delay};
  assign {hd_w, hd_h, hd_c, hd_s, hd_d} = head;
  assign run = any_run(i_ctrl_vsync_run, i_ctrl_hsync_run, i_ctrl_data_run);

  // Abort takes priority over a same-cycle push inside the queue.
  cnn_cmd_fifo #(.DW(CW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (i_cmd_valid),
    .pop   (pop),
    .flush (i_abort),
    .din   (push_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_q_level)
  );

  always_comb begin
    state_d  = state_q;
    width_d  = width_q;
    height_d = height_q;
    conv_d   = conv_q;
    sud_d    = sud_q;
    hsd_d    = hsd_q;
    fsize_d  = fsize_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pop      = 1'b0;
    case (state_q)
      S_IDLE:      if (!fifo_empty && !i_abort) state_d = S_LOAD;
      S_LOAD: begin
        pop     = 1'b1;
        state_d = S_IDLE;
        if (!i_abort) begin
          if (hd_w == '0 || hd_h == '0) begin
            err_d = 1'b1;
          end else begin
            width_d  = hd_w;
            height_d = hd_h;
            conv_d   = hd_c;
            sud_d    = hd_s;
            hsd_d    = hd_d;
            state_d  = S_MUL;
          end
        end
      end
      S_MUL: begin
        fsize_d = W_FRAME_SIZE'(width_q) * W_FRAME_SIZE'(height_q);
        state_d = S_START;
      end
      S_START:     state_d = S_WAIT_RUN;
      S_WAIT_RUN:  if (run) state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!run) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        cnt_d   = cnt_q + 16'd1;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      width_q  <= '0;
      height_q <= '0;
      conv_q   <= 1'b0;
      sud_q    <= '0;
      hsd_q    <= '0;
      fsize_q  <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      width_q  <= width_d;
      height_q <= height_d;
      conv_q   <= conv_d;
      sud_q    <= sud_d;
      hsd_q    <= hsd_d;
      fsize_q  <= fsize_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_cmd_ready      = !fifo_full;
  assign q_width          = width_q;
  assign q_height         = height_q;
  assign q_is_conv3x3     = conv_q;
  assign q_start_up_delay = sud_q;
  assign q_hsync_delay    = hsd_q;
  assign q_frame_size     = fsize_q;
  assign q_start          = (state_q == S_START);
  assign o_busy           = (state_q != S_IDLE);
  assign o_done           = done_q;
  assign o_err            = err_q;
  assign o_layer_cnt      = cnt_q;

`ifdef CNN_SCHED_PERF_EN
  // run_cnt_q holds the cycles elapsed since START, START included; +1 covers the o_done cycle.
  logic [31:0] run_cnt_q, run_cnt_d, last_q, last_d;

  always_comb begin
    run_cnt_d = run_cnt_q;
    last_d    = last_q;
    if (state_q == S_MUL) run_cnt_d = 32'd1;
    else if (state_q == S_START || state_q == S_WAIT_RUN || state_q == S_WAIT_DONE)
      run_cnt_d = run_cnt_q + 32'd1;
    if (state_q == S_WAIT_DONE && !run) last_d = run_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_cnt_q <= '0;
      last_q    <= '0;
    end else begin
      run_cnt_q <= run_cnt_d;
      last_q    <= last_d;
    end
  end

  assign o_last_cycles = last_q;
`endif

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Directed bench for cnn_layer_sched with a command scoreboard and a frame FSM model.
module tb_cnn_layer_sched;

  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [11:0] i_cmd_width = '0, i_cmd_height = '0;
  logic        i_cmd_is_conv3x3 = 1'b0;
  logic [11:0] i_cmd_start_up_delay = '0, i_cmd_hsync_delay = '0;
  logic        i_abort = 1'b0;
  logic        i_ctrl_vsync_run = 1'b0, i_ctrl_hsync_run = 1'b0, i_ctrl_data_run = 1'b0;
  logic [11:0] q_width, q_height;
  logic        q_is_conv3x3;
  logic [11:0] q_start_up_delay, q_hsync_delay;
  logic [24:0] q_frame_size;
  logic        q_start, o_busy, o_done, o_err;
  logic [15:0] o_layer_cnt;
  logic [2:0]  o_q_level;
`ifdef CNN_SCHED_PERF_EN
  logic [31:0] o_last_cycles;
`endif

  always #5 clk = ~clk;

  cnn_layer_sched dut (
    .clk(clk), .rstn(rstn),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_width(i_cmd_width), .i_cmd_height(i_cmd_height),
    .i_cmd_is_conv3x3(i_cmd_is_conv3x3),
    .i_cmd_start_up_delay(i_cmd_start_up_delay), .i_cmd_hsync_delay(i_cmd_hsync_delay),
    .i_abort(i_abort),
    .i_ctrl_vsync_run(i_ctrl_vsync_run), .i_ctrl_hsync_run(i_ctrl_hsync_run),
    .i_ctrl_data_run(i_ctrl_data_run),
    .q_width(q_width), .q_height(q_height), .q_is_conv3x3(q_is_conv3x3),
    .q_start_up_delay(q_start_up_delay), .q_hsync_delay(q_hsync_delay),
    .q_frame_size(q_frame_size), .q_start(q_start),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .o_layer_cnt(o_layer_cnt), .o_q_level(o_q_level)
`ifdef CNN_SCHED_PERF_EN
    , .o_last_cycles(o_last_cycles)
`endif
  );

  typedef struct { int w; int h; int c; int s; int d; } cmd_t;

  int   n_chk = 0, n_pass = 0;
  cmd_t exp_q[$];
  cmd_t cur, e;
  int   cyc = 0, st_cyc = 0, mdl_layer = 0, starts = 0, dones = 0;
  bit   in_frame = 0, prev_start = 0;
  int   fm_nv, fm_nh, fm_nd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: event not seen within bound", nm);
  endtask

  function automatic logic [63:0] pack_cmd(input cmd_t x);
    return 64'({12'(x.w), 12'(x.h), 1'(x.c), 12'(x.s), 12'(x.d)});
  endfunction

  function automatic logic [63:0] pack_dut();
    return 64'({q_width, q_height, q_is_conv3x3, q_start_up_delay, q_hsync_delay});
  endfunction

  // Frame FSM stand-in: vsync, then hsync, then data phases after each q_start.
  always begin
    @(negedge clk);
    if (rstn && q_start) begin
      fm_nv = (q_start_up_delay == 0) ? 1 : int'(q_start_up_delay);
      fm_nh = int'(q_hsync_delay);
      fm_nd = (q_height > 12'd16) ? 16 : int'(q_height);
      for (int i = 0; i < fm_nv + fm_nh + fm_nd; i++) begin
        @(negedge clk);
        if (!rstn) break;
        i_ctrl_vsync_run = (i < fm_nv);
        i_ctrl_hsync_run = (i >= fm_nv) && (i < fm_nv + fm_nh);
        i_ctrl_data_run  = (i >= fm_nv + fm_nh);
      end
      if (rstn) @(negedge clk);
      i_ctrl_vsync_run = 1'b0;
      i_ctrl_hsync_run = 1'b0;
      i_ctrl_data_run  = 1'b0;
    end
  end

  // Scoreboard: accepted commands launch or error out in order; config is held per frame.
  always @(negedge clk) begin
    cyc++;
    if (!rstn) begin
      exp_q.delete();
      in_frame   = 0;
      mdl_layer  = 0;
      prev_start = 0;
    end else begin
      if (q_start) begin
        chk("start_one_cycle", 64'(prev_start), 64'(0));
        if (exp_q.size() == 0) fail_now("start_without_cmd");
        else begin
          cur = exp_q.pop_front();
          chk("start_cfg", pack_dut(), pack_cmd(cur));
          chk("start_fsize", 64'(q_frame_size), 64'(cur.w * cur.h));
        end
        starts++;
        in_frame = 1;
        st_cyc   = cyc;
      end else if (in_frame) begin
        chk("cfg_stable", {pack_dut(), 39'(q_frame_size)} , {pack_cmd(cur), 39'(cur.w * cur.h)});
      end
      if (o_done) begin
        chk("done_in_frame", 64'(in_frame), 64'(1));
        in_frame = 0;
        mdl_layer++;
        dones++;
        chk("layer_cnt", 64'(o_layer_cnt), 64'(mdl_layer & 16'hffff));
`ifdef CNN_SCHED_PERF_EN
        chk("last_cycles", 64'(o_last_cycles), 64'(cyc - st_cyc + 1));
`endif
      end
      if (o_err) begin
        if (exp_q.size() == 0) fail_now("err_without_cmd");
        else begin
          e = exp_q.pop_front();
          chk("err_cmd_zero_dim", 64'(e.w == 0 || e.h == 0), 64'(1));
        end
      end
      chk("ready_vs_level", 64'(o_cmd_ready), 64'(int'(o_q_level) < FIFO_DEPTH));
      if (i_abort) exp_q.delete();
      else if (i_cmd_valid && o_cmd_ready)
        exp_q.push_back('{int'(i_cmd_width), int'(i_cmd_height), int'(i_cmd_is_conv3x3),
                          int'(i_cmd_start_up_delay), int'(i_cmd_hsync_delay)});
      prev_start = q_start;
    end
  end

  task automatic drive(input int w, input int h, input int c, input int s, input int d);
    i_cmd_width          = 12'(w);
    i_cmd_height         = 12'(h);
    i_cmd_is_conv3x3     = 1'(c);
    i_cmd_start_up_delay = 12'(s);
    i_cmd_hsync_delay    = 12'(d);
    i_cmd_valid          = 1'b1;
  endtask

  task automatic push1(input int w, input int h, input int c, input int s, input int d);
    @(posedge clk); #1;
    drive(w, h, c, s, d);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  // which: 0 = q_start, 1 = o_done, 2 = o_err; k counts negedges waited.
  task automatic wait_ev(input int which, input int max, output int k);
    k = 0;
    while (k < max) begin
      @(negedge clk);
      k++;
      if ((which == 0 && q_start) || (which == 1 && o_done) || (which == 2 && o_err)) return;
    end
    fail_now($sformatf("wait_event_%0d", which));
  endtask

  task automatic wait_idle(input int max);
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (!o_busy && o_q_level == 3'd0) return;
    end
    fail_now("wait_idle");
  endtask

  int k, s0, d0;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(o_busy), 64'(0));
    chk("rst_ready", 64'(o_cmd_ready), 64'(1));
    chk("rst_pulses", 64'({q_start, o_done, o_err}), 64'(0));
    chk("rst_cfg", pack_dut(), 64'(0));
    chk("rst_fsize", 64'(q_frame_size), 64'(0));
    chk("rst_level_cnt", 64'({o_q_level, o_layer_cnt}), 64'(0));
`ifdef CNN_SCHED_PERF_EN
    chk("rst_last_cycles", 64'(o_last_cycles), 64'(0));
`endif
    @(posedge clk); #1 rstn = 1'b1;

    // single 8x4 frame: four-cycle launch latency and 32-pixel frame size
    push1(8, 4, 0, 2, 3);
    wait_ev(0, 20, k);
    chk("t1_latency", 64'(k), 64'(4));
    chk("t1_fsize", 64'(q_frame_size), 64'(32));
    wait_ev(1, 100, k);
    chk("t1_layer_cnt", 64'(o_layer_cnt), 64'(1));

    // largest dimensions: product must not be truncated
    push1(4095, 4095, 1, 1, 0);
    wait_ev(0, 20, k);
    chk("big_fsize", 64'(q_frame_size), 64'(16769025));
    wait_ev(1, 100, k);

    // five back-to-back pushes while a long frame runs: only four fit
    push1(10, 20, 0, 2, 3);
    wait_ev(0, 20, k);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      drive(i + 1, i + 2, i % 2, 1, 1);
    end
    @(negedge clk);
    chk("t2_ready_full", 64'(o_cmd_ready), 64'(0));
    chk("t2_level_full", 64'(o_q_level), 64'(4));
    @(posedge clk); #1 i_cmd_valid = 1'b0;
    wait_idle(600);
    chk("t2_layer_cnt", 64'(o_layer_cnt), 64'(7));

    // zero-width command is rejected
    s0 = starts;
    push1(0, 5, 0, 1, 1);
    @(negedge clk);
    chk("t3_level_pre", 64'(o_q_level), 64'(1));
    wait_ev(2, 20, k);
    chk("t3_err_latency", 64'(k), 64'(2));
    chk("t3_level_post", 64'(o_q_level), 64'(0));
    repeat (10) @(negedge clk);
    chk("t3_no_start", 64'(starts), 64'(s0));

    // abort during the first of three queued frames
    @(posedge clk); #1 drive(3, 8, 0, 2, 2);
    @(posedge clk); #1 drive(4, 8, 1, 2, 2);
    @(posedge clk); #1 drive(5, 8, 0, 2, 2);
    @(posedge clk); #1 i_cmd_valid = 1'b0;
    wait_ev(0, 20, k);
    repeat (3) @(negedge clk);
    chk("t4_level_pre", 64'(o_q_level), 64'(2));
    @(posedge clk); #1 i_abort = 1'b1;
    @(posedge clk); #1 i_abort = 1'b0;
    @(negedge clk);
    chk("t4_level_flushed", 64'(o_q_level), 64'(0));
    s0 = starts;
    wait_ev(1, 100, k);
    chk("t4_layer_cnt", 64'(o_layer_cnt), 64'(8));
    repeat (30) @(negedge clk);
    chk("t4_no_start", 64'(starts), 64'(s0));

    // reset in the middle of a frame
    push1(5, 10, 0, 1, 1);
    wait_ev(0, 20, k);
    repeat (4) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t5_busy", 64'(o_busy), 64'(0));
    chk("t5_pulses", 64'({q_start, o_done, o_err}), 64'(0));
    chk("t5_cfg", pack_dut(), 64'(0));
    chk("t5_fsize", 64'(q_frame_size), 64'(0));
    chk("t5_cnt_level", 64'({o_q_level, o_layer_cnt}), 64'(0));
    chk("t5_ready", 64'(o_cmd_ready), 64'(1));
    d0 = dones;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (30) @(negedge clk);
    chk("t5_no_done", 64'(dones), 64'(d0));
    chk("t5_layer_cnt", 64'(o_layer_cnt), 64'(0));

    // 4x4 conv3x3 frame: seven run cycles give START..done of 10
    push1(4, 4, 1, 2, 1);
    wait_ev(0, 20, k);
    wait_ev(1, 100, k);
    chk("t6_layer_cnt", 64'(o_layer_cnt), 64'(1));
`ifdef CNN_SCHED_PERF_EN
    chk("t6_last_cycles", 64'(o_last_cycles), 64'(10));
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
